// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential sign-magnitude restoring divider:
// default operand widths, the controller state encoding, the display sign
// codes and the helper that turns the quotient sign into a display code.
// -----------------------------------------------------------------------------
package div_pkg;

    // Dividend / quotient magnitude width (matches the multiplier product).
    localparam int DVD_W_DEF = 14;
    // Divisor width including its sign bit.
    localparam int DVS_W_DEF = 8;
    // Width of the step counter for the default dividend width.
    localparam int CNT_W     = $clog2(DVD_W_DEF);

    // Display sign codes shared with the multiplier result path.
    localparam logic [3:0] SIGN_MINUS = 4'b1010;
    localparam logic [3:0] SIGN_PLUS  = 4'b0000;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } div_state_e;

    // Display sign for a finished division. A zero quotient is always shown
    // as positive so the display never shows a negative zero; a divide-by-zero
    // result is also shown as positive.
    function automatic logic [3:0] sign_code(input logic sign_xor,
                                             input logic quot_nonzero,
                                             input logic div_zero);
        logic [3:0] code;
        if (sign_xor && quot_nonzero && !div_zero) begin
            code = SIGN_MINUS;
        end else begin
            code = SIGN_PLUS;
        end
        return code;
    endfunction

endpackage

// File: rtl/seq_divider_restoring_div_step.sv
// -----------------------------------------------------------------------------
// restoring_div_step
// One combinational restoring-division step.
//   rem_i  : current partial remainder (DVS_W bits)
//   bit_i  : next dividend bit, taken from the top of the shift register
//   dvs_i  : divisor magnitude (DVS_W-1 bits)
//   rem_o  : partial remainder after the step
//   q_o    : quotient bit produced by the step
// -----------------------------------------------------------------------------
module restoring_div_step
    import div_pkg::*;
#(
    parameter int DVS_W = DVS_W_DEF
) (
    input  logic [DVS_W-1:0] rem_i,
    input  logic             bit_i,
    input  logic [DVS_W-2:0] dvs_i,
    output logic [DVS_W-1:0] rem_o,
    output logic             q_o
);

    // The remainder entering a step is always below the divisor, so its top
    // bit is zero and the shifted value fits in DVS_W bits. The compare is
    // still done one bit wider so the step is exact for any input.
    logic [DVS_W:0] p_wide_s;
    logic [DVS_W:0] dvs_wide_s;
    logic [DVS_W:0] diff_s;

    // Trial subtraction: keep the difference when it does not go negative.
    always_comb begin
        p_wide_s   = {rem_i, bit_i};
        dvs_wide_s = {2'b00, dvs_i};
        diff_s     = p_wide_s - dvs_wide_s;
        if (p_wide_s >= dvs_wide_s) begin
            q_o   = 1'b1;
            rem_o = diff_s[DVS_W-1:0];
        end else begin
            q_o   = 1'b0;
            rem_o = p_wide_s[DVS_W-1:0];
        end
    end

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Sequential sign-magnitude restoring divider, one quotient bit per clock.
// Takes the multiplier's product format (magnitude + sign flag) as dividend
// and an 8-bit sign-magnitude divisor; returns quotient magnitude, remainder
// magnitude and the 4-bit display sign code.
//
// Ports:
//   clock         rising-edge clock
//   reset         synchronous active-high reset
//   start         request, honoured in IDLE and in DONE once done is high
//   dividend_mag  dividend magnitude
//   dividend_neg  dividend sign (1 = negative)
//   divisor       sign-magnitude divisor, [DVS_W-1] sign
//   busy          high while iterating
//   done          result valid, held until the next accepted start
//   quotient      quotient magnitude
//   remainder     remainder magnitude
//   sign          SIGN_MINUS for a negative nonzero quotient, else SIGN_PLUS
//   div_err       divide-by-zero flag
//
// Build option: define DIV_ZERO_DETECT_EN to short-circuit a zero divisor
// magnitude straight to DONE with div_err set. Without it a zero divisor runs
// the normal iteration and div_err stays low.
// -----------------------------------------------------------------------------
module seq_divider
    import div_pkg::*;
#(
    parameter int DVD_W = DVD_W_DEF,
    parameter int DVS_W = DVS_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend_mag,
    input  logic             dividend_neg,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-2:0] remainder,
    output logic [3:0]       sign,
    output logic             div_err
);

    localparam int CW = $clog2(DVD_W);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DVD_W - 1);

    div_state_e       state_q,   state_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [DVS_W-1:0] rem_w_q,   rem_w_d;    // working partial remainder
    logic [DVD_W-1:0] shreg_q,   shreg_d;    // dividend in, quotient out
    logic [DVS_W-2:0] dvs_q,     dvs_d;
    logic             sxor_q,    sxor_d;
    logic             divz_q,    divz_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic [DVD_W-1:0] quot_q,    quot_d;
    logic [DVS_W-2:0] rem_q,     rem_d;
    logic [3:0]       sign_q,    sign_d;
    logic             div_err_q, div_err_d;

    logic [DVS_W-1:0] step_rem_s;
    logic             step_qbit_s;
    logic             accept_s;
    logic             dvs_zero_s;

    restoring_div_step #(
        .DVS_W (DVS_W)
    ) u_step (
        .rem_i (rem_w_q),
        .bit_i (shreg_q[DVD_W-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem_s),
        .q_o   (step_qbit_s)
    );

    // A new request is taken in IDLE, or in DONE once the previous result has
    // been published, so every result is visible for at least one cycle.
    always_comb begin
        if (start && ((state_q == IDLE) || ((state_q == DONE) && done_q))) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Zero-divisor detection is compiled in only when the option is enabled.
    always_comb begin
`ifdef DIV_ZERO_DETECT_EN
        if (divisor[DVS_W-2:0] == {(DVS_W-1){1'b0}}) begin
            dvs_zero_s = 1'b1;
        end else begin
            dvs_zero_s = 1'b0;
        end
`else
        dvs_zero_s = 1'b0;
`endif
    end

    // Controller and datapath next-state logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_w_d   = rem_w_q;
        shreg_d   = shreg_q;
        dvs_d     = dvs_q;
        sxor_d    = sxor_q;
        divz_d    = divz_q;
        busy_d    = busy_q;
        done_d    = done_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        sign_d    = sign_q;
        div_err_d = div_err_q;

        if (accept_s) begin
            // Latch operands; inputs are free to change after this edge.
            dvs_d     = divisor[DVS_W-2:0];
            sxor_d    = dividend_neg ^ divisor[DVS_W-1];
            done_d    = 1'b0;
            div_err_d = 1'b0;
            rem_w_d   = {DVS_W{1'b0}};
            if (dvs_zero_s) begin
                shreg_d = {DVD_W{1'b1}};
                divz_d  = 1'b1;
                cnt_d   = {CW{1'b0}};
                busy_d  = 1'b0;
                state_d = DONE;
            end else begin
                shreg_d = dividend_mag;
                divz_d  = 1'b0;
                cnt_d   = CNT_LOAD;
                busy_d  = 1'b1;
                state_d = RUN;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                RUN: begin
                    // Dividend bits leave at the top while quotient bits enter
                    // at the bottom; after DVD_W steps the register is the quotient.
                    rem_w_d = step_rem_s;
                    shreg_d = {shreg_q[DVD_W-2:0], step_qbit_s};
                    if (cnt_q == {CW{1'b0}}) begin
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    // Publish the result once on the first DONE cycle.
                    if (!done_q) begin
                        quot_d    = shreg_q;
                        rem_d     = rem_w_q[DVS_W-2:0];
                        sign_d    = sign_code(sxor_q, (shreg_q != {DVD_W{1'b0}}), divz_q);
                        div_err_d = divz_q;
                        done_d    = 1'b1;
                    end else begin
                        done_d    = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= {CW{1'b0}};
            rem_w_q   <= {DVS_W{1'b0}};
            shreg_q   <= {DVD_W{1'b0}};
            dvs_q     <= {(DVS_W-1){1'b0}};
            sxor_q    <= 1'b0;
            divz_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quot_q    <= {DVD_W{1'b0}};
            rem_q     <= {(DVS_W-1){1'b0}};
            sign_q    <= SIGN_PLUS;
            div_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_w_q   <= rem_w_d;
            shreg_q   <= shreg_d;
            dvs_q     <= dvs_d;
            sxor_q    <= sxor_d;
            divz_q    <= divz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            sign_q    <= sign_d;
            div_err_q <= div_err_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign sign      = sign_q;
    assign div_err   = div_err_q;

endmodule
